// File: rtl/dmem_lsu_if.sv
// Core-side load/store handshake plus the banked data-memory port.
// The slave modport is the LSU view. The master modport is the view of
// whatever sits around it: the core and the memory.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_dataIn;
  logic        mem_rW;
  logic        mem_en;
  logic [31:0] mem_dataOut;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataOut,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_dataIn, mem_rW, mem_en
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataOut,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_dataIn, mem_rW, mem_en
  );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I load/store unit in front of a word-wide banked data memory.
// The unit handles one request at a time.
// - A load reads the word, then extracts and extends the addressed lane.
// - A sub-word store reads the word, merges the new lane, then writes it back.
// - A word store writes the word directly.
// A misaligned access or an illegal funct3 is answered at once with an error
// response, and the memory is never touched.
module dmem_lsu #(
  parameter int READ_LAT = 2,
  parameter int WR_LAT   = 2
) (
  input logic        clk,
  input logic        rst,
  dmem_lsu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LAT);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       wword_q, wword_d;

  // Flags a misaligned access or a funct3 that is illegal for this direction.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic e;
    case (f3)
      F3_B:    e = 1'b0;
      F3_H:    e = a[0];
      F3_W:    e = (a != 2'b00);
      F3_BU:   e = we;
      F3_HU:   e = we | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Selects the addressed lane of a read word, then sign- or zero-extends it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'h0, b};
      F3_HU:   r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Writes the store lane into the read word and keeps all other bytes.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [2:0] f3,
                                              input logic [1:0] a);
    logic [31:0] w;
    w = word;
    case (f3)
      F3_B: begin
        case (a)
          2'd0:    w[7:0]   = wd[7:0];
          2'd1:    w[15:8]  = wd[7:0];
          2'd2:    w[23:16] = wd[7:0];
          default: w[31:24] = wd[7:0];
        endcase
      end
      F3_H: begin
        if (a[1]) w[31:16] = wd[15:0];
        else      w[15:0]  = wd[15:0];
      end
      default: w = wd;
    endcase
    return w;
  endfunction

  // Next-state logic: sequences IDLE -> (RD) -> (WR) -> RESP and updates
  // the captured request and data words.
  always_comb begin
    // NOTE: every signal gets a default first so that no path leaves it
    // unassigned. A path without an assignment would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    wword_d  = wword_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          err_d    = access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
          rdata_d  = '0;
          wword_d  = bus.req_wdata;
          cnt_d    = '0;
          if (err_d)                                state_d = RESP;
          else if (bus.req_we && bus.req_funct3 == F3_W) state_d = WR;
          else                                      state_d = RD;
        end
      end
      RD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RD_LAST) begin
          cnt_d = '0;
          if (we_q) begin
            wword_d = store_merge(bus.mem_dataOut, wdata_q, funct3_q, addr_q[1:0]);
            state_d = WR;
          end else begin
            rdata_d = load_extract(bus.mem_dataOut, funct3_q, addr_q[1:0]);
            state_d = RESP;
          end
        end
      end
      WR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. A synchronous reset aborts any access
  // that is in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. This makes
    // every register sample values from before the edge.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      wword_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      wword_q  <= wword_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE) && !rst;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_en     = (state_q == RD) || (state_q == WR);
  assign bus.mem_rW     = (state_q == WR);
  assign bus.mem_addr   = {2'b00, addr_q[31:2]};
  assign bus.mem_dataIn = wword_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu. It uses a small word memory model that
// commits a write only after WR_LAT consecutive write cycles.
module tb_dmem_lsu;
  localparam int READ_LAT = 2;
  localparam int WR_LAT   = 2;

  logic clk = 1'b0;
  logic rst;

  dmem_lsu_if bus();

  dmem_lsu #(.READ_LAT(READ_LAT), .WR_LAT(WR_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write committed on the last WR cycle.
  logic [31:0] mem [1024] = '{default: '0};
  int          wcnt = 0;
  assign bus.mem_dataOut = mem[bus.mem_addr[9:0]];

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_rW) begin
      if (wcnt == WR_LAT - 1) begin
        mem[bus.mem_addr[9:0]] <= bus.mem_dataIn;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[$];

  // Issues one request, then follows it to its response and checks the
  // memory-port behaviour along the way.
  task automatic run_req(input vec_t v);
    int          lat;
    int          wr_cycles;
    logic        seen_en;
    logic        addr_bad;
    logic        din_bad;
    logic [31:0] rd;
    logic        er;
    lat = 0; wr_cycles = 0; seen_en = 0; addr_bad = 0; din_bad = 0; rd = '0; er = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    check({v.name, " ready"}, 32'(bus.req_ready), 32'd1);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // The accepted fields must be latched, so scramble the inputs.
        bus.req_valid  = 1'b0;
        bus.req_we     = ~v.we;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'hFFFF_FFFC;
        bus.req_wdata  = 32'h0BAD_F00D;
      end
      if (bus.mem_en) begin
        seen_en = 1'b1;
        if (bus.mem_addr !== {2'b00, v.addr[31:2]}) addr_bad = 1'b1;
      end
      if (bus.mem_en && bus.mem_rW) begin
        wr_cycles++;
        if (bus.mem_dataIn !== v.exp_word) din_bad = 1'b1;
      end
      if (bus.resp_valid) begin
        lat = k;
        rd  = bus.resp_rdata;
        er  = bus.resp_err;
      end
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, " rdata"}, rd, v.exp_rdata);
    check({v.name, " err"}, 32'(er), 32'(v.exp_err));
    check({v.name, " mem_en seen"}, 32'(seen_en), 32'(!v.exp_err));
    check({v.name, " wr cycles"}, 32'(wr_cycles),
          32'((v.we && !v.exp_err) ? WR_LAT : 0));
    check({v.name, " mem_addr"}, 32'(addr_bad), 32'd0);
    check({v.name, " mem_dataIn"}, 32'(din_bad), 32'd0);
    if (v.we && !v.exp_err)
      check({v.name, " mem word"}, mem[v.addr[11:2]], v.exp_word);
    @(negedge clk);
    check({v.name, " resp one cycle"}, 32'(bus.resp_valid), 32'd0);
    check({v.name, " back to idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  int accepts, resps, resp_cyc, gap_bad, data_bad, late_resp;

  initial begin
    //                name        we  f3      addr          wdata         rdata         err lat word
    vecs.push_back('{"SW 404",    1, 3'b010, 32'h0000_0404, 32'hDEAD_BEEF, 32'h0,         0, 3, 32'hDEAD_BEEF});
    vecs.push_back('{"LW 404",    0, 3'b010, 32'h0000_0404, 32'h0,         32'hDEAD_BEEF, 0, 4, 32'h0});
    vecs.push_back('{"LB 405",    0, 3'b000, 32'h0000_0405, 32'h0,         32'hFFFF_FFBE, 0, 4, 32'h0});
    vecs.push_back('{"LBU 405",   0, 3'b100, 32'h0000_0405, 32'h0,         32'h0000_00BE, 0, 4, 32'h0});
    vecs.push_back('{"LH 406",    0, 3'b001, 32'h0000_0406, 32'h0,         32'hFFFF_DEAD, 0, 4, 32'h0});
    vecs.push_back('{"LHU 406",   0, 3'b101, 32'h0000_0406, 32'h0,         32'h0000_DEAD, 0, 4, 32'h0});
    vecs.push_back('{"SB 407",    1, 3'b000, 32'h0000_0407, 32'h0000_0012, 32'h0,         0, 6, 32'h12AD_BEEF});
    vecs.push_back('{"SH 404",    1, 3'b001, 32'h0000_0404, 32'h0000_CAFE, 32'h0,         0, 6, 32'h12AD_CAFE});
    vecs.push_back('{"LW 402",    0, 3'b010, 32'h0000_0402, 32'h0,         32'h0,         1, 1, 32'h0});
    vecs.push_back('{"SH 401",    1, 3'b001, 32'h0000_0401, 32'h0000_1111, 32'h0,         1, 1, 32'h0});
    vecs.push_back('{"LD f3=011", 0, 3'b011, 32'h0000_0404, 32'h0,         32'h0,         1, 1, 32'h0});
    vecs.push_back('{"LD f3=110", 0, 3'b110, 32'h0000_0404, 32'h0,         32'h0,         1, 1, 32'h0});
    vecs.push_back('{"ST f3=100", 1, 3'b100, 32'h0000_0404, 32'h0000_0077, 32'h0,         1, 1, 32'h0});
    vecs.push_back('{"SW 406",    1, 3'b010, 32'h0000_0406, 32'h1234_5678, 32'h0,         1, 1, 32'h0});
    vecs.push_back('{"LB 404",    0, 3'b000, 32'h0000_0404, 32'h0,         32'hFFFF_FFFE, 0, 4, 32'h0});
    vecs.push_back('{"LB 407",    0, 3'b000, 32'h0000_0407, 32'h0,         32'h0000_0012, 0, 4, 32'h0});
    vecs.push_back('{"LHU 404",   0, 3'b101, 32'h0000_0404, 32'h0,         32'h0000_CAFE, 0, 4, 32'h0});
    vecs.push_back('{"SH 406",    1, 3'b001, 32'h0000_0406, 32'h1234_5678, 32'h0,         0, 6, 32'h5678_CAFE});
    vecs.push_back('{"LH 406b",   0, 3'b001, 32'h0000_0406, 32'h0,         32'h0000_5678, 0, 4, 32'h0});
    vecs.push_back('{"LW 404b",   0, 3'b010, 32'h0000_0404, 32'h0,         32'h5678_CAFE, 0, 4, 32'h0});

    // Reset state, with a request pending so that acceptance is blocked.
    rst            = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000_0404;
    bus.req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst req_ready",  32'(bus.req_ready),  32'd0);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_err",   32'(bus.resp_err),   32'd0);
    check("rst resp_rdata", bus.resp_rdata,      32'd0);
    check("rst mem_en",     32'(bus.mem_en),     32'd0);
    check("rst mem_rW",     32'(bus.mem_rW),     32'd0);
    check("rst mem_addr",   bus.mem_addr,        32'd0);
    check("rst mem_dataIn", bus.mem_dataIn,      32'd0);
    bus.req_valid = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    check("post-rst req_ready", 32'(bus.req_ready), 32'd1);

    foreach (vecs[i]) run_req(vecs[i]);

    // Reset during the first WR cycle of an SB aborts the write.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0000_0404;
    bus.req_wdata  = 32'h0000_0055;
    late_resp = 0;
    check("abort ready", 32'(bus.req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.resp_valid) late_resp++;
    end
    @(negedge clk);
    check("abort in WR", 32'(bus.mem_en && bus.mem_rW), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort mem_en", 32'(bus.mem_en), 32'd0);
    check("abort ready under rst", 32'(bus.req_ready), 32'd0);
    if (bus.resp_valid) late_resp++;
    rst = 1'b0;
    @(negedge clk);
    check("abort ready after rst", 32'(bus.req_ready), 32'd1);
    repeat (8) begin
      if (bus.resp_valid) late_resp++;
      @(negedge clk);
    end
    check("abort no resp", 32'(late_resp), 32'd0);
    check("abort mem word", mem[10'h101], 32'h5678_CAFE);

    // req_valid held high across three back-to-back LW requests.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000_0404;
    bus.req_wdata  = 32'h0;
    accepts = 0; resps = 0; resp_cyc = -10; gap_bad = 0; data_bad = 0;
    for (int cyc = 0; cyc < 60 && resps < 3; cyc++) begin
      if (accepts == 3) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        resps++;
        resp_cyc = cyc;
        if (bus.resp_rdata !== 32'h5678_CAFE) data_bad++;
      end
      if (bus.req_valid && bus.req_ready) begin
        if (accepts > 0 && cyc != resp_cyc + 1) gap_bad++;
        accepts++;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (6) begin
      if (bus.resp_valid) resps++;
      @(negedge clk);
    end
    check("b2b accepts", 32'(accepts),  32'd3);
    check("b2b resps",   32'(resps),    32'd3);
    check("b2b spacing", 32'(gap_bad),  32'd0);
    check("b2b rdata",   32'(data_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
